// File: rtl/xgmii_rx_link_fault.sv
// xgmii_rx_link_fault
// Link fault monitor for the 64-bit XGMII receive path.
// Each word carries two columns. Column A (lane 0) is processed before column B (lane 4).
// The monitor tracks local/remote fault sequences and clean-column windows.
// From these it reports the link as OK, local fault or remote fault.

module xgmii_rx_link_fault #(
    parameter int COL_WINDOW = 128,
    parameter int SEQ_THRESH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 rx_block_lock,
    output logic [1:0]           link_status,
    output logic                 link_up,
    output logic                 status_change,
    output logic [CNT_WIDTH-1:0] fault_count
);

    localparam int COL_W = $clog2(COL_WINDOW + 1);
    localparam int SEQ_W = $clog2(SEQ_THRESH + 1);

    typedef enum logic [1:0] {
        LINK_OK     = 2'd0,
        LINK_LOCAL  = 2'd1,
        LINK_REMOTE = 2'd2
    } link_state_t;

    typedef enum logic [1:0] {
        SEQ_NONE   = 2'd0,
        SEQ_LOCAL  = 2'd1,
        SEQ_REMOTE = 2'd2
    } seq_type_t;

    link_state_t      state_q, state_d;
    seq_type_t        last_q, last_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [COL_W-1:0] col_q, col_d;
    seq_type_t        col_type_a, col_type_b;
    seq_type_t        cur_type;

    // A fault sequence is ||Q|| with control only on byte 0.
    // Bytes 1-2 are zero, and byte 3 selects local (0x01) or remote (0x02).
    // Anything else is an ordinary column.
    function automatic seq_type_t classify(input logic [31:0] d, input logic [3:0] c);
        seq_type_t t;
        t = SEQ_NONE;
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0000) begin
            if (d[31:24] == 8'h01) begin
                t = SEQ_LOCAL;
            end else if (d[31:24] == 8'h02) begin
                t = SEQ_REMOTE;
            end
        end
        return t;
    endfunction

    assign col_type_a = classify(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
    assign col_type_b = classify(xgmii_rxd[63:32], xgmii_rxc[7:4]);

    // Walk both columns in order; loss of block lock overrides the whole word.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        seq_d    = seq_q;
        col_d    = col_q;
        cur_type = SEQ_NONE;
        for (int i = 0; i < 2; i++) begin
            cur_type = (i == 0) ? col_type_a : col_type_b;
            if (cur_type != SEQ_NONE) begin
                col_d = '0;
                if (cur_type != last_d) begin
                    last_d = cur_type;
                    seq_d  = SEQ_W'(1);
                end else if (seq_d >= SEQ_W'(SEQ_THRESH - 1)) begin
                    seq_d   = SEQ_W'(SEQ_THRESH);
                    state_d = (cur_type == SEQ_LOCAL) ? LINK_LOCAL : LINK_REMOTE;
                end else begin
                    seq_d = seq_d + SEQ_W'(1);
                end
            end else if (col_d == COL_W'(COL_WINDOW - 1)) begin
                state_d = LINK_OK;
                seq_d   = '0;
                col_d   = '0;
                last_d  = SEQ_NONE;
            end else begin
                col_d = col_d + COL_W'(1);
            end
        end
        if (!rx_block_lock) begin
            state_d = LINK_LOCAL;
            seq_d   = '0;
            col_d   = '0;
            last_d  = SEQ_NONE;
        end
    end

    // State register plus the registered change pulse and OK-to-fault event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LINK_LOCAL;
            last_q        <= SEQ_NONE;
            seq_q         <= '0;
            col_q         <= '0;
            status_change <= 1'b0;
            fault_count   <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            seq_q         <= seq_d;
            col_q         <= col_d;
            status_change <= (state_d != state_q);
            if (state_q == LINK_OK && state_d != LINK_OK && fault_count != '1) begin
                fault_count <= fault_count + CNT_WIDTH'(1);
            end
        end
    end

    assign link_status = state_q;
    assign link_up     = (state_q == LINK_OK);

endmodule

// File: tb/tb_xgmii_rx_link_fault.sv
// tb_xgmii_rx_link_fault
// Directed testbench for the XGMII receive link fault monitor.
// It covers recovery windows, the sequence threshold and lock loss.
// It also covers malformed sequences, fault-to-fault changes and asynchronous reset.

module tb_xgmii_rx_link_fault;

    localparam logic [63:0] IDLE_D     = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C     = 8'hFF;
    localparam logic [31:0] IDLE_LANE  = 32'h07070707;
    localparam logic [31:0] LOCAL_SEQ  = 32'h0100009C;
    localparam logic [31:0] REMOTE_SEQ = 32'h0200009C;
    localparam logic [31:0] BAD_SEQ    = 32'h0300009C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        rx_block_lock;
    logic [1:0]  link_status;
    logic        link_up;
    logic        status_change;
    logic [15:0] fault_count;

    int checkCount = 0;
    int errorCount = 0;

    xgmii_rx_link_fault #(
        .COL_WINDOW(128),
        .SEQ_THRESH(4),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .xgmii_rxd    (xgmii_rxd),
        .xgmii_rxc    (xgmii_rxc),
        .rx_block_lock(rx_block_lock),
        .link_status  (link_status),
        .link_up      (link_up),
        .status_change(status_change),
        .fault_count  (fault_count)
    );

    // Free-running 100 MHz receive clock.
    always #5 clk = ~clk;

    // Drive one word, let it be clocked in, then settle just past the edge.
    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c, input logic lock);
        xgmii_rxd     = d;
        xgmii_rxc     = c;
        rx_block_lock = lock;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        rst_n         = 1'b0;
        xgmii_rxd     = IDLE_D;
        xgmii_rxc     = IDLE_C;
        rx_block_lock = 1'b1;
        #12;
        checkOutput("reset_status", 32'(link_status), 32'd1);
        checkOutput("reset_up", 32'(link_up), 32'd0);
        checkOutput("reset_change", 32'(status_change), 32'd0);
        checkOutput("reset_count", 32'(fault_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] step 1: initial recovery after 64 idle words");
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(IDLE_D, IDLE_C, 1'b1);
            checkOutput("t1_hold", 32'(link_status), 32'd1);
        end
        applyStimulus(IDLE_D, IDLE_C, 1'b1);
        checkOutput("t1_ok", 32'(link_status), 32'd0);
        checkOutput("t1_up", 32'(link_up), 32'd1);
        checkOutput("t1_change", 32'(status_change), 32'd1);
        checkOutput("t1_count", 32'(fault_count), 32'd0);
        applyStimulus(IDLE_D, IDLE_C, 1'b1);
        checkOutput("t1_change_end", 32'(status_change), 32'd0);

        $display("[TB] step 2: four local sequences then recovery");
        for (int i = 1; i <= 3; i++) begin
            applyStimulus({IDLE_LANE, LOCAL_SEQ}, 8'hF1, 1'b1);
        end
        checkOutput("t2_below_thresh", 32'(link_status), 32'd0);
        applyStimulus({IDLE_LANE, LOCAL_SEQ}, 8'hF1, 1'b1);
        checkOutput("t2_local", 32'(link_status), 32'd1);
        checkOutput("t2_up", 32'(link_up), 32'd0);
        checkOutput("t2_change", 32'(status_change), 32'd1);
        checkOutput("t2_count", 32'(fault_count), 32'd1);
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(IDLE_D, IDLE_C, 1'b1);
            checkOutput("t2_hold", 32'(link_status), 32'd1);
            if (i == 1) checkOutput("t2_change_end", 32'(status_change), 32'd0);
        end
        applyStimulus(IDLE_D, IDLE_C, 1'b1);
        checkOutput("t2_ok", 32'(link_status), 32'd0);
        checkOutput("t2_change_ok", 32'(status_change), 32'd1);
        checkOutput("t2_count_ok", 32'(fault_count), 32'd1);

        $display("[TB] step 3: alternating sequence types never reach threshold");
        for (int i = 0; i < 8; i++) begin
            applyStimulus({IDLE_LANE, (i % 2 == 0) ? LOCAL_SEQ : REMOTE_SEQ}, 8'hF1, 1'b1);
            checkOutput("t3_status", 32'(link_status), 32'd0);
            checkOutput("t3_change", 32'(status_change), 32'd0);
        end

        $display("[TB] step 4: remote sequences in both lanes");
        applyStimulus({REMOTE_SEQ, REMOTE_SEQ}, 8'h11, 1'b1);
        checkOutput("t4_first", 32'(link_status), 32'd0);
        applyStimulus({REMOTE_SEQ, REMOTE_SEQ}, 8'h11, 1'b1);
        checkOutput("t4_remote", 32'(link_status), 32'd2);
        checkOutput("t4_change", 32'(status_change), 32'd1);
        checkOutput("t4_count", 32'(fault_count), 32'd2);
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(IDLE_D, IDLE_C, 1'b1);
        end
        checkOutput("t4_hold", 32'(link_status), 32'd2);
        applyStimulus(IDLE_D, IDLE_C, 1'b1);
        checkOutput("t4_ok", 32'(link_status), 32'd0);

        $display("[TB] step 5: lock loss during remote accumulation");
        applyStimulus({REMOTE_SEQ, REMOTE_SEQ}, 8'h11, 1'b1);
        applyStimulus({IDLE_LANE, REMOTE_SEQ}, 8'hF1, 1'b1);
        checkOutput("t5_accum", 32'(link_status), 32'd0);
        applyStimulus({REMOTE_SEQ, REMOTE_SEQ}, 8'h11, 1'b0);
        checkOutput("t5_lock_local", 32'(link_status), 32'd1);
        checkOutput("t5_change", 32'(status_change), 32'd1);
        checkOutput("t5_count", 32'(fault_count), 32'd3);
        for (int i = 1; i <= 63; i++) begin
            applyStimulus(IDLE_D, IDLE_C, 1'b1);
        end
        checkOutput("t5_hold", 32'(link_status), 32'd1);
        applyStimulus(IDLE_D, IDLE_C, 1'b1);
        checkOutput("t5_ok", 32'(link_status), 32'd0);
        checkOutput("t5_change_ok", 32'(status_change), 32'd1);

        $display("[TB] step 6: malformed sequences are ordinary columns");
        for (int i = 0; i < 100; i++) begin
            applyStimulus({IDLE_LANE, BAD_SEQ}, 8'hF1, 1'b1);
            checkOutput("t6_code", 32'(link_status), 32'd0);
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus({IDLE_LANE, LOCAL_SEQ}, 8'hF0, 1'b1);
            checkOutput("t6_noctl", 32'(link_status), 32'd0);
        end
        checkOutput("t6_change", 32'(status_change), 32'd0);
        checkOutput("t6_count", 32'(fault_count), 32'd3);

        $display("[TB] step 7: local to remote without counting");
        applyStimulus({LOCAL_SEQ, LOCAL_SEQ}, 8'h11, 1'b1);
        checkOutput("t7_first", 32'(link_status), 32'd0);
        applyStimulus({LOCAL_SEQ, LOCAL_SEQ}, 8'h11, 1'b1);
        checkOutput("t7_local", 32'(link_status), 32'd1);
        checkOutput("t7_count_local", 32'(fault_count), 32'd4);
        applyStimulus({REMOTE_SEQ, REMOTE_SEQ}, 8'h11, 1'b1);
        checkOutput("t7_still_local", 32'(link_status), 32'd1);
        checkOutput("t7_change_quiet", 32'(status_change), 32'd0);
        applyStimulus({REMOTE_SEQ, REMOTE_SEQ}, 8'h11, 1'b1);
        checkOutput("t7_remote", 32'(link_status), 32'd2);
        checkOutput("t7_change", 32'(status_change), 32'd1);
        checkOutput("t7_count_remote", 32'(fault_count), 32'd4);

        $display("[TB] step 8: asynchronous reset mid-operation");
        for (int i = 1; i <= 64; i++) begin
            applyStimulus(IDLE_D, IDLE_C, 1'b1);
        end
        checkOutput("t8_pre_ok", 32'(link_up), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t8_status", 32'(link_status), 32'd1);
        checkOutput("t8_up", 32'(link_up), 32'd0);
        checkOutput("t8_change", 32'(status_change), 32'd0);
        checkOutput("t8_count", 32'(fault_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
